// File: rtl/serial_and_deserializer.sv
// Bit-serial AND stage consumer: forms o = b ? a : 0 per accepted beat and packs
// the results LSB-first into WIDTH-bit words emitted over a valid/ready output.
module serial_and_deserializer #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic             up_a,
    input  logic             up_b,
    input  logic             up_last,
    output logic             down_valid,
    input  logic             down_ready,
    output logic [WIDTH-1:0] down_data,
    output logic [CW-1:0]    down_count
);

    // Handshake rules: a beat moves on up_valid && up_ready, a word moves on
    // down_valid && down_ready; up_ready only depends on the output register
    // and down_ready, so a held word blocks input and an accepted word frees
    // the slot in the same cycle.
    localparam logic [CW-1:0] last_idx = CW'(WIDTH - 1);

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] next_word;
    logic             beat_bit;
    logic             accept;
    logic             close;

    assign up_ready = !down_valid || down_ready;
    assign accept   = up_valid && up_ready;
    assign beat_bit = up_b ? up_a : 1'b0;
    assign close    = accept && ((cnt == last_idx) || up_last);

    always_comb begin
        next_word = word | ({{(WIDTH-1){1'b0}}, beat_bit} << cnt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            word       <= '0;
            down_valid <= 1'b0;
            down_data  <= '0;
            down_count <= '0;
        end else begin
            if (accept) begin
                if (close) begin
                    cnt  <= '0;
                    word <= '0;
                end else begin
                    cnt  <= cnt + CW'(1);
                    word <= next_word;
                end
            end
            // A closing beat can only be accepted when the output slot is free
            // or being drained this edge, so loading here never clobbers a held word.
            if (close) begin
                down_data  <= next_word;
                down_count <= cnt + CW'(1);
                down_valid <= 1'b1;
            end else if (down_valid && down_ready) begin
                down_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_and_deserializer.sv
// Directed bench for serial_and_deserializer (WIDTH=8): reset, full and early words,
// backpressure, back-to-back words, 1-bit overlap words and reset mid-word.
module tb_serial_and_deserializer;

    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH + 1);

    logic             clk;
    logic             rst;
    logic             up_valid;
    logic             up_ready;
    logic             up_a;
    logic             up_b;
    logic             up_last;
    logic             down_valid;
    logic             down_ready;
    logic [WIDTH-1:0] down_data;
    logic [CW-1:0]    down_count;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] pats [3];
    logic [WIDTH-1:0] exp_word;

    serial_and_deserializer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_a       (up_a),
        .up_b       (up_b),
        .up_last    (up_last),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_data  (down_data),
        .down_count (down_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic a, input logic b, input logic last);
        up_valid = 1'b1;
        up_a     = a;
        up_b     = b;
        up_last  = last;
        tick();
        up_valid = 1'b0;
        up_a     = 1'b0;
        up_b     = 1'b0;
        up_last  = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // 1: reset with random inputs
        rst        = 1'b1;
        up_valid   = 1'($urandom_range(0, 1));
        up_a       = 1'($urandom_range(0, 1));
        up_b       = 1'($urandom_range(0, 1));
        up_last    = 1'($urandom_range(0, 1));
        down_ready = 1'($urandom_range(0, 1));
        #1;
        check("rst_valid", 32'(down_valid), 32'd0);
        check("rst_data", 32'(down_data), 32'd0);
        check("rst_count", 32'(down_count), 32'd0);
        tick();
        tick();
        check("rst_valid_held", 32'(down_valid), 32'd0);
        up_valid   = 1'b0;
        up_a       = 1'b0;
        up_b       = 1'b0;
        up_last    = 1'b0;
        down_ready = 1'b1;
        rst        = 1'b0;
        #1;
        check("rst_up_ready", 32'(up_ready), 32'd1);

        // 2: full word, expected 8'b0100_1111
        beat(1, 1, 0); beat(1, 1, 0); beat(1, 1, 0); beat(1, 1, 0);
        beat(1, 0, 0); beat(0, 1, 0); beat(1, 1, 0);
        check("full_not_early", 32'(down_valid), 32'd0);
        beat(0, 0, 0);
        check("full_valid", 32'(down_valid), 32'd1);
        check("full_data", 32'(down_data), 32'h4F);
        check("full_count", 32'(down_count), 32'd8);

        // 3: early close on up_last
        beat(1, 1, 0);
        check("early_drained", 32'(down_valid), 32'd0);
        beat(1, 1, 0);
        beat(1, 1, 1);
        check("early_valid", 32'(down_valid), 32'd1);
        check("early_data", 32'(down_data), 32'h07);
        check("early_count", 32'(down_count), 32'd3);
        tick();
        check("early_idle", 32'(down_valid), 32'd0);

        // 4: backpressure, word 1 = 8'h55 held while input is stalled
        down_ready = 1'b0;
        beat(1, 1, 0); beat(0, 1, 0); beat(1, 1, 0); beat(1, 0, 0);
        beat(1, 1, 0); beat(0, 0, 0); beat(1, 1, 0); beat(0, 1, 0);
        check("bp_valid", 32'(down_valid), 32'd1);
        check("bp_data", 32'(down_data), 32'h55);
        check("bp_up_ready", 32'(up_ready), 32'd0);
        up_valid = 1'b1;
        up_a     = 1'b1;
        up_b     = 1'b1;
        up_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", 32'(down_valid), 32'd1);
            check("bp_hold_data", 32'(down_data), 32'h55);
            check("bp_hold_count", 32'(down_count), 32'd8);
            check("bp_hold_ready", 32'(up_ready), 32'd0);
        end
        up_valid   = 1'b0;
        up_last    = 1'b0;
        down_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(up_ready), 32'd1);
        beat(1, 1, 0);
        check("bp_word1_taken", 32'(down_valid), 32'd0);
        beat(1, 1, 0); beat(0, 0, 0); beat(1, 1, 1);
        check("bp_w2_valid", 32'(down_valid), 32'd1);
        check("bp_w2_data", 32'(down_data), 32'h0B);
        check("bp_w2_count", 32'(down_count), 32'd4);

        // 5: back-to-back words, last word closes with up_last on bit 7
        pats[0] = 8'hA5;
        pats[1] = 8'h3C;
        pats[2] = 8'hF0;
        for (int w = 0; w < 3; w++) begin
            exp_q.push_back(pats[w]);
            for (int i = 0; i < WIDTH; i++) begin
                if (pats[w][i])
                    beat(1, 1, (w == 2) && (i == WIDTH - 1));
                else if (i % 3 == 0)
                    beat(0, 1, (w == 2) && (i == WIDTH - 1));
                else if (i % 3 == 1)
                    beat(1, 0, (w == 2) && (i == WIDTH - 1));
                else
                    beat(0, 0, (w == 2) && (i == WIDTH - 1));
                if (i == 3)
                    check("b2b_mid_idle", 32'(down_valid), 32'd0);
            end
            check("b2b_valid", 32'(down_valid), 32'd1);
            exp_word = exp_q.pop_front();
            check("b2b_data", 32'(down_data), 32'(exp_word));
            check("b2b_count", 32'(down_count), 32'd8);
        end
        check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);
        tick();
        check("b2b_no_duplicate", 32'(down_valid), 32'd0);

        // 1-bit words back-to-back: close and accept overlap every edge
        beat(1, 1, 1);
        check("one_valid_a", 32'(down_valid), 32'd1);
        check("one_data_a", 32'(down_data), 32'h01);
        check("one_count_a", 32'(down_count), 32'd1);
        beat(0, 1, 1);
        check("one_valid_b", 32'(down_valid), 32'd1);
        check("one_data_b", 32'(down_data), 32'h00);
        beat(1, 1, 1);
        check("one_valid_c", 32'(down_valid), 32'd1);
        check("one_data_c", 32'(down_data), 32'h01);
        check("one_count_c", 32'(down_count), 32'd1);

        // 6: reset mid-word discards the partial bits
        beat(1, 1, 0); beat(1, 1, 0); beat(0, 1, 0); beat(1, 1, 0); beat(1, 1, 0);
        check("mid_partial_idle", 32'(down_valid), 32'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(down_valid), 32'd0);
        check("mid_rst_data", 32'(down_data), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        for (int i = 0; i < WIDTH - 1; i++) begin
            beat(1, 1, 0);
            check("mid_no_stale", 32'(down_valid), 32'd0);
        end
        beat(1, 1, 0);
        check("mid_valid", 32'(down_valid), 32'd1);
        check("mid_data", 32'(down_data), 32'hFF);
        check("mid_count", 32'(down_count), 32'd8);
        tick();
        check("mid_single_word", 32'(down_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
